// File: rtl/mips_mmio_pkg.sv
// Shared MMIO map for the single-cycle MIPS data-side responder.
// Holds the register offsets, STATUS bit layout and default console FIFO depth.
package mips_mmio_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;

  localparam logic [7:0]  OFF_GPIO   = 8'h00;
  localparam logic [7:0]  OFF_CYCLE  = 8'h04;
  localparam logic [7:0]  OFF_TCMP   = 8'h08;
  localparam logic [7:0]  OFF_STATUS = 8'h0C;
  localparam logic [7:0]  OFF_TXDATA = 8'h10;

  localparam int ST_FLAG   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 6;

  localparam int TXF_DEPTH_DEF = 4;

  typedef struct packed {
    logic gpio;
    logic cycle;
    logic tcmp;
    logic status;
    logic txdata;
  } mmio_sel_t;

  // Register select from the word offset inside the MMIO page.
  function automatic mmio_sel_t mmio_decode(input logic hit, input logic [7:0] off);
    mmio_sel_t s;
    s        = '0;
    s.gpio   = hit && (off == OFF_GPIO);
    s.cycle  = hit && (off == OFF_CYCLE);
    s.tcmp   = hit && (off == OFF_TCMP);
    s.status = hit && (off == OFF_STATUS);
    s.txdata = hit && (off == OFF_TXDATA);
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console TX FIFO: power-of-two depth, head byte visible combinationally.
// Caller guarantees pop only when non-empty and push only when room (or popping).
module tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rp];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory for a single-cycle core: word RAM plus an MMIO page with
// GPIO, free-running cycle counter, compare timer and a console TX FIFO.
module data_mem_responder
  import mips_mmio_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int TXF_DEPTH = TXF_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  gpio_out,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TXF_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_q, tcmp_q;
  logic [7:0]    gpio_q;
  logic          flag_q, ovf_q;

  logic          ram_hit, mmio_hit, we;
  logic [AW-1:0] widx;
  mmio_sel_t     sel;

  logic          f_full, f_empty, f_push, f_pop;
  logic [CW-1:0] f_count;
  logic [31:0]   cnt_ext, status;
  logic          tmatch, ovf_evt;

  logic          unused_addr;
  assign unused_addr = ^addr[1:0];

  assign ram_hit  = (addr[31:AW+2] == '0);
  assign mmio_hit = (addr[31:8] == MMIO_BASE[31:8]);
  assign widx     = addr[AW+1:2];
  assign sel      = mmio_decode(mmio_hit, {addr[7:2], 2'b00});
  // A store issued in the reset cycle is dropped everywhere, RAM included.
  assign we       = memwrite && !reset;

  assign f_pop   = !f_empty && tx_ready;
  assign f_push  = we && sel.txdata && (!f_full || f_pop);
  assign ovf_evt = we && sel.txdata && f_full && !f_pop;
  assign tmatch  = (cycle_q == tcmp_q) && (tcmp_q != '0);

  tx_fifo #(.DEPTH(TXF_DEPTH), .W(8)) u_txf (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .din   (writedata[7:0]),
    .pop   (f_pop),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count),
    .head  (tx_data)
  );

  always_ff @(posedge clk) begin
    if (we && ram_hit) ram[widx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      tcmp_q  <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (we && sel.gpio) gpio_q <= writedata[7:0];
      if (we && sel.tcmp) tcmp_q <= writedata;
      // Set beats a same-edge write-one-to-clear for both sticky bits.
      if (tmatch)                                      flag_q <= 1'b1;
      else if (we && sel.status && writedata[ST_FLAG]) flag_q <= 1'b0;
      if (ovf_evt)                                     ovf_q  <= 1'b1;
      else if (we && sel.status && writedata[ST_OVF])  ovf_q  <= 1'b0;
    end
  end

  assign cnt_ext = 32'(f_count);

  always_comb begin
    status                      = '0;
    status[ST_FLAG]             = flag_q;
    status[ST_FULL]             = f_full;
    status[ST_EMPTY]            = f_empty;
    status[ST_OVF]              = ovf_q;
    status[ST_CNT_HI:ST_CNT_LO] = cnt_ext[ST_CNT_HI-ST_CNT_LO:0];
  end

  always_comb begin
    readdata = '0;
    if (ram_hit)         readdata = ram[widx];
    else if (sel.gpio)   readdata = {24'b0, gpio_q};
    else if (sel.cycle)  readdata = cycle_q;
    else if (sel.tcmp)   readdata = tcmp_q;
    else if (sel.status) readdata = status;
  end

  assign gpio_out = gpio_q;
  assign irq      = flag_q;
  assign tx_valid = !f_empty;

endmodule
